dt_input_queue: RTL and testbench
=================================

Name: dt_input_queue

Overview:
- Per-source ingress buffer that feeds one input port (in_nX) of the 4-in/5-out destination crossbar.
- Queues packets from a source, presents the head packet in crossbar input format {valid, dest[2:0], data[15:0]} and holds it until the crossbar acks.
- Rejects illegal destinations at enqueue and discards a head packet that has waited TIMEOUT cycles without an ack, so one lost arbitration cannot block the source forever.
- Four instances sit directly upstream of the crossbar, one per input.

Parameters:
- DEPTH, 4: queue entries; power of two, >= 2.
- TIMEOUT, 16: cycles the head may wait un-acked before it is discarded; 0 disables discard.
- MAX_DEST, 4: highest legal destination index.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_valid  in  1  source offers a packet this cycle.
- wr_dest  in  3  destination output index.
- wr_data  in  16  payload.
- wr_ready  out  1  queue can accept a packet this cycle.
- pkt  out  20  to crossbar in_nX: {pkt[19] = valid, pkt[18:16] = dest, pkt[15:0] = data}.
- ack  in  1  crossbar ack_nX for the packet currently on pkt.
- count  out  $clog2(DEPTH)+1  current occupancy.
- bad_dest  out  1  one-cycle pulse: an offered packet was rejected for illegal destination.
- drop  out  1  one-cycle pulse: the head packet was discarded on timeout.

Behaviour:
- Reset (async assert, any time, including mid-transfer):
  - count = 0, read/write pointers = 0, wait counter = 0.
  - pkt = 20'b0, wr_ready = 1, bad_dest = 0, drop = 0.
  - Queue contents are lost.
- Ready: wr_ready = (count < DEPTH). It is combinational from registered count only, never from ack; there is no full-queue bypass.
- Enqueue:
  - A packet is accepted when wr_valid && wr_ready && wr_dest <= MAX_DEST.
  - It is written at the write pointer; the pointer wraps modulo DEPTH.
- Reject:
  - When wr_valid && wr_ready && wr_dest > MAX_DEST, nothing is stored and bad_dest = 1 on the next cycle.
  - wr_valid while wr_ready = 0 is ignored and produces no pulse; the source must hold the packet.
- Presentation:
  - pkt = {count != 0, head dest, head data}.
  - When count == 0, pkt[18:0] = 0.
  - Latency from an accepted write into an empty queue to pkt[19] = 1 is 1 cycle. Write and read are never bypassed in the same cycle.
- Pop:
  - The head pops when ack && pkt[19]; the read pointer advances and wraps modulo DEPTH.
  - ack while pkt[19] = 0 is ignored.
  - The crossbar's ack is combinational from pkt, so the next entry is visible on the cycle after the pop.
- Simultaneous push and pop: count stays unchanged. With count == DEPTH the push is refused (wr_ready = 0) even when ack pops that cycle.
- Wait counter:
  - Clears on every pop, on drop, and whenever pkt[19] = 0.
  - Otherwise increments each cycle pkt[19] = 1 && !ack.
- Timeout discard (TIMEOUT > 0):
  - If wait counter == TIMEOUT-1 && pkt[19] && !ack, the head pops without delivery and drop = 1 on the next cycle.
  - An ack in that same cycle wins: normal pop, no drop.
  - A push in that cycle behaves as a push with pop.
- Counter widths: wait counter is $clog2(TIMEOUT+1) bits and saturates; it never wraps.
- All outputs other than pkt and wr_ready are registered. pkt is a mux from queue storage indexed by the registered read pointer; there is no combinational path from ack to pkt.

Test Plan:
- Reset then idle: rst pulsed for 2 cycles, no traffic -> pkt = 20'h00000, count = 0, wr_ready = 1, no pulses.
- Single transfer: write dest=3, data=16'hBEEF into empty queue, ack=1 on the first cycle pkt is valid -> pkt = 20'hBBEEF exactly one cycle after the write; count returns 1 -> 0 after the ack cycle.
- Fill/backpressure/wrap:
  - Write 4 packets with data 1..4 and no ack -> count = 4, wr_ready = 0; a 5th write is refused and produces no bad_dest.
  - Then ack 4 times and write 4 more -> output order is 1,2,3,4 followed by the new packets, confirming pointer wrap.
- Full push+pop: count = 4, ack and wr_valid in the same cycle -> push refused, count = 3; a repeat next cycle is accepted with count staying at 3.
- Illegal destination: write dest=5, then dest=7 -> bad_dest pulses one cycle after each write; count stays 0; pkt[19] stays 0.
- Timeout (TIMEOUT=16):
  - Head held with ack=0 -> drop pulses 16 cycles after the head first appears, and the next entry is presented the following cycle.
  - Repeat with ack=1 in cycle 16 -> normal pop, drop = 0.
  - Assert rst mid-wait -> everything clears, no drop pulse.

Source files
------------

// File: rtl/dt_input_queue_if.sv
// Ingress handshake bundle between a source, the input queue and one
// crossbar input port.
interface dt_input_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          wr_valid;
  logic [2:0]    wr_dest;
  logic [15:0]   wr_data;
  logic          wr_ready;
  logic [19:0]   pkt;
  logic          ack;
  logic [CW-1:0] count;
  logic          bad_dest;
  logic          drop;

  modport master (
    output wr_valid, wr_dest, wr_data, ack,
    input  wr_ready, pkt, count, bad_dest, drop
  );

  modport slave (
    input  wr_valid, wr_dest, wr_data, ack,
    output wr_ready, pkt, count, bad_dest, drop
  );
endinterface

// File: rtl/dt_input_queue.sv
// Per-source ingress FIFO for one crossbar input: filters illegal
// destinations and discards a head packet left un-acked too long.
module dt_input_queue #(
  parameter int DEPTH    = 4,
  parameter int TIMEOUT  = 16,
  parameter int MAX_DEST = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  dt_input_queue_if.slave         q
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  logic [2:0]    r_dest [DEPTH];
  logic [15:0]   r_data [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [TW-1:0] r_wait;
  logic          r_bad;
  logic          r_drop;

  logic w_valid;
  logic w_ready;
  logic w_legal;
  logic w_push;
  logic w_rej;
  logic w_tmo;
  logic w_pop;

  assign w_valid = (r_count != '0);
  assign w_ready = (r_count < CW'(DEPTH));
  assign w_legal = (q.wr_dest <= 3'(MAX_DEST));
  assign w_push  = q.wr_valid && w_ready && w_legal;
  assign w_rej   = q.wr_valid && w_ready && !w_legal;

  // An ack in the expiry cycle takes precedence over the discard.
  assign w_tmo = (TIMEOUT > 0) && w_valid && !q.ack &&
                 (r_wait == TW'(TLIM));
  assign w_pop = (w_valid && q.ack) || w_tmo;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_dest[r_wptr] <= q.wr_dest;
      r_data[r_wptr] <= q.wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_wait  <= '0;
      r_bad   <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_bad  <= w_rej;
      r_drop <= w_tmo;
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_pop || !w_valid)
        r_wait <= '0;
      else if (r_wait != TW'(TIMEOUT))
        r_wait <= r_wait + TW'(1);
    end
  end

  assign q.wr_ready = w_ready;
  assign q.pkt      = w_valid ?
                      {1'b1, r_dest[r_rptr], r_data[r_rptr]} :
                      20'h0;
  assign q.count    = r_count;
  assign q.bad_dest = r_bad;
  assign q.drop     = r_drop;
endmodule

// File: tb/tb_dt_input_queue.sv
// Directed bench for dt_input_queue: reset, transfer, fill/wrap,
// full push+pop, illegal destinations and head timeout.
module tb_dt_input_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  dt_input_queue_if #(.DEPTH(4)) q_if ();

  dt_input_queue #(
    .DEPTH(4),
    .TIMEOUT(16),
    .MAX_DEST(4)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .q(q_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [2:0] d, input logic [15:0] v);
    q_if.wr_valid = 1'b1;
    q_if.wr_dest  = d;
    q_if.wr_data  = v;
    tick();
    q_if.wr_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    q_if.wr_valid = 1'b0;
    q_if.wr_dest  = 3'd0;
    q_if.wr_data  = 16'h0;
    q_if.ack      = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_pkt",   32'(q_if.pkt),      32'h0);
    chk("rst_count", 32'(q_if.count),    32'd0);
    chk("rst_ready", 32'(q_if.wr_ready), 32'd1);
    chk("rst_bad",   32'(q_if.bad_dest), 32'd0);
    chk("rst_drop",  32'(q_if.drop),     32'd0);

    put(3'd3, 16'hBEEF);
    chk("one_pkt",   32'(q_if.pkt),   32'hBBEEF);
    chk("one_cnt1",  32'(q_if.count), 32'd1);
    q_if.ack = 1'b1;
    tick();
    q_if.ack = 1'b0;
    chk("one_cnt0",  32'(q_if.count), 32'd0);
    chk("one_empty", 32'(q_if.pkt),   32'h0);

    for (int i = 1; i <= 4; i++) put(3'd1, 16'(i));
    chk("fill_cnt",   32'(q_if.count),    32'd4);
    chk("fill_ready", 32'(q_if.wr_ready), 32'd0);
    put(3'd1, 16'd5);
    chk("fill_refuse", 32'(q_if.count),    32'd4);
    chk("fill_nobad",  32'(q_if.bad_dest), 32'd0);
    q_if.ack = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("order_a", 32'(q_if.pkt), {12'h0, 4'h9, 16'(i)});
      tick();
    end
    q_if.ack = 1'b0;
    chk("drain_cnt", 32'(q_if.count), 32'd0);
    for (int i = 0; i < 4; i++) put(3'd2, 16'h0011 + 16'(i));
    q_if.ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("order_wrap", 32'(q_if.pkt), {12'h0, 4'hA, 16'h0011 + 16'(i)});
      tick();
    end
    q_if.ack = 1'b0;
    chk("wrap_cnt", 32'(q_if.count), 32'd0);

    for (int i = 0; i < 4; i++) put(3'd0, 16'h0021 + 16'(i));
    q_if.ack      = 1'b1;
    q_if.wr_valid = 1'b1;
    q_if.wr_dest  = 3'd0;
    q_if.wr_data  = 16'h0025;
    tick();
    chk("full_pp_cnt", 32'(q_if.count), 32'd3);
    tick();
    q_if.wr_valid = 1'b0;
    chk("pp_cnt",  32'(q_if.count), 32'd3);
    chk("pp_head", 32'(q_if.pkt),   32'h80023);
    for (int i = 0; i < 3; i++) begin
      chk("pp_order", 32'(q_if.pkt), 32'h80023 + 32'(i));
      tick();
    end
    q_if.ack = 1'b0;
    chk("pp_empty", 32'(q_if.count), 32'd0);

    put(3'd5, 16'h1234);
    chk("bad5_pulse", 32'(q_if.bad_dest), 32'd1);
    chk("bad5_cnt",   32'(q_if.count),    32'd0);
    chk("bad5_valid", 32'(q_if.pkt[19]),  32'd0);
    tick();
    chk("bad5_clear", 32'(q_if.bad_dest), 32'd0);
    put(3'd7, 16'h5678);
    chk("bad7_pulse", 32'(q_if.bad_dest), 32'd1);
    chk("bad7_cnt",   32'(q_if.count),    32'd0);
    chk("bad7_valid", 32'(q_if.pkt[19]),  32'd0);
    tick();
    chk("bad7_clear", 32'(q_if.bad_dest), 32'd0);

    put(3'd2, 16'h00A1);
    put(3'd4, 16'h00A2);
    repeat (14) tick();
    chk("to_nodrop15", 32'(q_if.drop), 32'd0);
    chk("to_head15",   32'(q_if.pkt),  32'hA00A1);
    tick();
    chk("to_drop",  32'(q_if.drop),  32'd1);
    chk("to_next",  32'(q_if.pkt),   32'hC00A2);
    chk("to_cnt",   32'(q_if.count), 32'd1);
    tick();
    chk("to_pulse1", 32'(q_if.drop), 32'd0);
    repeat (14) tick();
    q_if.ack = 1'b1;
    tick();
    q_if.ack = 1'b0;
    chk("ack_wins_drop", 32'(q_if.drop),  32'd0);
    chk("ack_wins_cnt",  32'(q_if.count), 32'd0);
    tick();
    chk("ack_wins_late", 32'(q_if.drop),  32'd0);

    put(3'd1, 16'h00B1);
    repeat (8) tick();
    rst = 1'b1;
    #1;
    chk("arst_cnt", 32'(q_if.count), 32'd0);
    chk("arst_pkt", 32'(q_if.pkt),   32'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("arst_nodrop", 32'(q_if.drop), 32'd0);
      tick();
    end
    chk("arst_ready", 32'(q_if.wr_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
